wb_crc_engine: RTL and testbench
================================

Name: wb_crc_engine

Overview:
- Wishbone pipelined slave that computes a parametrised CRC (width 8..32) over bytes written by the Ibex core.
- Hardware successor to the software crc_32 workload. Width, polynomial, init, xorout and reflection are configurable.
- Sits as an extra slave on wb_interconnect_sharedbus beside wb_spramx32.
- Processes one byte per clock; throttles the bus with stall while bytes are pending.

Parameters:
- CRC_WIDTH, 32: CRC register width, legal 8..32.
- POLY, 32'h04C11DB7: generator polynomial, normal form, low CRC_WIDTH bits used.
- INIT, 32'hFFFFFFFF: value loaded on reset and on CTRL.clear.
- XOROUT, 32'hFFFFFFFF: XOR applied to the result on read.
- REFIN_RST, 1'b1: reset value of CTRL.refin.
- REFOUT_RST, 1'b1: reset value of CTRL.refout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wb  wb_if.slave  -  Wishbone B4 pipelined slave: adr, dat_m, dat_s, sel, we, cyc, stb, ack, err, stall. Word-aligned, 32-bit data.

Behaviour:
- Register map (adr[3:2]):
  - 0 CTRL, RW: bit0 refin, bit1 refout, bit2 clear (write-1 pulse, reads 0).
  - 1 DATA, WO: bytes to process.
  - 2 RESULT, RO: result after refout and XOROUT, zero-extended to 32 bits.
  - 3 STATUS, RO: bit0 busy, bits[3:1] pending byte count.
- Reset (async): crc=INIT; refin=REFIN_RST; refout=REFOUT_RST; pending=0; ack=0; err=0; stall=0; dat_s=0.
- Handshake:
  - A request is accepted when cyc & stb & !stall.
  - ack (or err) pulses exactly one cycle after acceptance; dat_s is valid with it.
  - Only one request is outstanding.
- DATA write:
  - Each byte lane with sel set is queued, lowest lane first (little-endian stream).
  - sel=0 still acks and queues nothing.
- Processing:
  - One byte per clock, starting the cycle after acceptance.
  - A 4-lane write is complete 4 cycles after acceptance.
  - refin reverses bit order within each byte before the step.
  - The step XORs the byte into the top 8 bits of crc, then runs 8 shift/conditional-XOR(POLY) iterations masked to CRC_WIDTH.
  - For CRC_WIDTH<8, not legal; an elaboration assertion rejects it.
- stall is high while pending!=0. Any new request, read or write, waits, so RESULT and STATUS reads always see the settled value.
- CTRL write with clear=1:
  - Accepted only when idle, which stall guarantees.
  - Loads INIT the cycle after acceptance.
  - refin/refout take the written values in the same write.
- RESULT read: refout reverses all CRC_WIDTH bits, then XOROUT is applied. Reading does not modify state.
- Write to RESULT/STATUS or read of DATA: err instead of ack, no state change. adr bits outside [3:2] are ignored.
- cyc dropping mid-stall: nothing accepted, no ack. Queued bytes from an earlier accepted write still complete.
- rst_n asserted mid-processing: pending is discarded, crc returns to INIT immediately. No ack after reset.
- Back-to-back: the next request may be accepted in the cycle pending reaches 0 (stall low that cycle).

Decomposition:
- Package wb_crc_pkg holds:
  - register offsets (CTRL=0, DATA=1, RESULT=2, STATUS=3) and CTRL bit indices;
  - function reflect_byte;
  - parametrised function reflect_n.
- Sub-module crc_byte_step (parameters CRC_WIDTH, POLY), purely combinational: crc_in + byte -> crc_out. Instantiated once.
- The top holds the register file, a 4-entry byte queue with count, and the Wishbone FSM. FSM states:
  - IDLE;
  - RESP (ack/err cycle);
  - BUSY (pending!=0).

Test Plan:
- Default params; write "1234","5678" as full words, then "9" with sel=0001; read RESULT -> 32'hCBF43926. STATUS reads 0 once idle.
- CRC_WIDTH=16, POLY=16'h1021, INIT=16'hFFFF, XOROUT=0, REFIN/REFOUT=0; same 9 bytes -> RESULT 32'h000029B1.
- Write DATA sel=1111, then immediately issue a RESULT read -> stall high exactly 4 cycles, then read acks with the final value. No overlap of ack pulses.
- After data, write CTRL=3'b111 -> next RESULT read returns INIT^XOROUT = 32'h00000000. CTRL reads 32'h3.
- Write RESULT; read DATA -> each gets a single err pulse, no ack, and RESULT is unchanged.
- Assert rst_n low 2 cycles after a 4-byte DATA write -> stall=0, pending=0, ack=0 immediately. After release, RESULT reads 32'h00000000 (default params).

Source files
------------

// File: rtl/wb_crc_engine_pkg.sv
// Shared definitions for the Wishbone CRC engine: register map, CTRL bit
// positions, bus FSM states and bit-reflection helpers.
package wb_crc_pkg;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_RESULT = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_REFIN  = 0;
   localparam int CTRL_REFOUT = 1;
   localparam int CTRL_CLEAR  = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESP,
      ST_BUSY
   } wb_state_e;

   function automatic logic [7:0] reflect_byte(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[3'(i)] = b[3'(7 - i)];
      end
      return r;
   endfunction

   // Reverses the low n bits of v; bits at and above n come back as zero.
   function automatic logic [31:0] reflect_n(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < n) begin
            r[5'(i)] = v[5'(n - 1 - i)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_crc_engine_if.sv
// Wishbone B4 pipelined bus bundle, 32-bit word-aligned data.
interface wb_if;
   logic [31:0] adr;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic        ack;
   logic        err;
   logic        stall;

   modport master (
      output adr, dat_m, sel, we, cyc, stb,
      input  dat_s, ack, err, stall
   );

   modport slave (
      input  adr, dat_m, sel, we, cyc, stb,
      output dat_s, ack, err, stall
   );
endinterface

// File: rtl/wb_crc_engine_byte_step.sv
// One byte of a normal-form (MSB-first) CRC update, purely combinational.
module crc_byte_step #(
   parameter int          CRC_WIDTH = 32,
   parameter logic [31:0] POLY      = 32'h04C11DB7
) (
   input  logic [CRC_WIDTH-1:0] crc_in,
   input  logic [7:0]           data_in,
   output logic [CRC_WIDTH-1:0] crc_out
);

   localparam logic [CRC_WIDTH-1:0] POLY_W = POLY[CRC_WIDTH-1:0];

   logic [CRC_WIDTH-1:0] acc;

   always_comb begin
      acc = crc_in ^ (CRC_WIDTH'(data_in) << (CRC_WIDTH - 8));
      for (int i = 0; i < 8; i++) begin
         acc = acc[CRC_WIDTH-1] ? ((acc << 1) ^ POLY_W) : (acc << 1);
      end
      crc_out = acc;
   end

endmodule

// File: rtl/wb_crc_engine.sv
// Wishbone pipelined slave computing a parametrised CRC over written bytes,
// one byte per clock, stalling the bus while queued bytes remain.
module wb_crc_engine
   import wb_crc_pkg::*;
#(
   parameter int          CRC_WIDTH  = 32,
   parameter logic [31:0] POLY       = 32'h04C11DB7,
   parameter logic [31:0] INIT       = 32'hFFFFFFFF,
   parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
   parameter logic        REFIN_RST  = 1'b1,
   parameter logic        REFOUT_RST = 1'b1
) (
   input logic clk,
   input logic rst_n,
   wb_if.slave wb
);

   if (CRC_WIDTH < 8 || CRC_WIDTH > 32) begin : g_bad_width
      $error("wb_crc_engine: CRC_WIDTH must lie in 8..32");
   end

   localparam logic [CRC_WIDTH-1:0] INIT_W   = INIT[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] XOROUT_W = XOROUT[CRC_WIDTH-1:0];

   wb_state_e            state_q, state_d;
   logic [CRC_WIDTH-1:0] crc_q, crc_d;
   logic                 refin_q, refin_d;
   logic                 refout_q, refout_d;
   logic [7:0]           queue_q [4];
   logic [7:0]           queue_d [4];
   logic [2:0]           count_q, count_d;
   logic                 resp_err_q, resp_err_d;
   logic [31:0]          dat_s_q, dat_s_d;

   logic                 accept;
   logic [1:0]           reg_sel;
   logic [7:0]           step_byte;
   logic [CRC_WIDTH-1:0] step_crc;
   logic [31:0]          refl_full;
   logic [CRC_WIDTH-1:0] result_w;
   logic [2:0]           fill;
   logic                 unused_bits;

   assign reg_sel     = wb.adr[3:2];
   assign accept      = wb.cyc & wb.stb & ~wb.stall;
   assign wb.stall    = (count_q != 3'd0);
   assign wb.ack      = (state_q == ST_RESP) & ~resp_err_q;
   assign wb.err      = (state_q == ST_RESP) & resp_err_q;
   assign wb.dat_s    = dat_s_q;
   assign step_byte   = refin_q ? reflect_byte(queue_q[0]) : queue_q[0];
   assign unused_bits = ^{wb.adr[31:4], wb.adr[1:0], refl_full};

   crc_byte_step #(
      .CRC_WIDTH(CRC_WIDTH),
      .POLY     (POLY)
   ) u_step (
      .crc_in (crc_q),
      .data_in(step_byte),
      .crc_out(step_crc)
   );

   always_comb begin
      refl_full = reflect_n(32'(crc_q), CRC_WIDTH);
      result_w  = (refout_q ? refl_full[CRC_WIDTH-1:0] : crc_q) ^ XOROUT_W;
   end

   // Queue head is consumed every cycle it is non-empty; a new request can
   // only be accepted once the queue has drained, so the two never overlap.
   always_comb begin
      crc_d      = crc_q;
      refin_d    = refin_q;
      refout_d   = refout_q;
      queue_d    = queue_q;
      count_d    = count_q;
      resp_err_d = resp_err_q;
      dat_s_d    = '0;
      fill       = 3'd0;

      if (count_q != 3'd0) begin
         crc_d      = step_crc;
         queue_d[0] = queue_q[1];
         queue_d[1] = queue_q[2];
         queue_d[2] = queue_q[3];
         queue_d[3] = 8'h00;
         count_d    = count_q - 3'd1;
      end

      if (accept) begin
         resp_err_d = 1'b0;
         case (reg_sel)
            REG_CTRL: begin
               if (wb.we) begin
                  refin_d  = wb.dat_m[CTRL_REFIN];
                  refout_d = wb.dat_m[CTRL_REFOUT];
                  if (wb.dat_m[CTRL_CLEAR]) begin
                     crc_d = INIT_W;
                  end
               end else begin
                  dat_s_d = 32'({refout_q, refin_q});
               end
            end
            REG_DATA: begin
               if (wb.we) begin
                  for (int l = 0; l < 4; l++) begin
                     if (wb.sel[2'(l)]) begin
                        queue_d[fill[1:0]] = wb.dat_m[5'(8 * l) +: 8];
                        fill               = fill + 3'd1;
                     end
                  end
                  count_d = fill;
               end else begin
                  resp_err_d = 1'b1;
               end
            end
            REG_RESULT: begin
               if (wb.we) begin
                  resp_err_d = 1'b1;
               end else begin
                  dat_s_d = 32'(result_w);
               end
            end
            default: begin
               if (wb.we) begin
                  resp_err_d = 1'b1;
               end else begin
                  dat_s_d = {28'h0, count_q, count_q != 3'd0};
               end
            end
         endcase
      end

      if (accept) begin
         state_d = ST_RESP;
      end else if (count_d != 3'd0) begin
         state_d = ST_BUSY;
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         crc_q      <= INIT_W;
         refin_q    <= REFIN_RST;
         refout_q   <= REFOUT_RST;
         queue_q    <= '{default: 8'h00};
         count_q    <= 3'd0;
         resp_err_q <= 1'b0;
         dat_s_q    <= '0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         refin_q    <= refin_d;
         refout_q   <= refout_d;
         queue_q    <= queue_d;
         count_q    <= count_d;
         resp_err_q <= resp_err_d;
         dat_s_q    <= dat_s_d;
      end
   end

endmodule

// File: tb/tb_wb_crc_engine.sv
// Bench for wb_crc_engine: a CRC-32 and a CRC-16/CCITT-FALSE instance driven
// in lockstep, responses checked against a bit-serial reference model.
module tb_wb_crc_engine;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m_adr, m_dat;
   logic [3:0]  m_sel;
   logic        m_we, m_cyc, m_stb;

   wb_if wb0();
   wb_if wb1();

   assign wb0.adr = m_adr;  assign wb1.adr = m_adr;
   assign wb0.dat_m = m_dat; assign wb1.dat_m = m_dat;
   assign wb0.sel = m_sel;  assign wb1.sel = m_sel;
   assign wb0.we = m_we;    assign wb1.we = m_we;
   assign wb0.cyc = m_cyc;  assign wb1.cyc = m_cyc;
   assign wb0.stb = m_stb;  assign wb1.stb = m_stb;

   wb_crc_engine u_dut32 (
      .clk  (clk),
      .rst_n(rst_n),
      .wb   (wb0)
   );

   wb_crc_engine #(
      .CRC_WIDTH (16),
      .POLY      (32'h0000_1021),
      .INIT      (32'h0000_FFFF),
      .XOROUT    (32'h0000_0000),
      .REFIN_RST (1'b0),
      .REFOUT_RST(1'b0)
   ) u_dut16 (
      .clk  (clk),
      .rst_n(rst_n),
      .wb   (wb1)
   );

   // Reference model configuration: index 0 is the CRC-32 instance, 1 the CRC-16.
   int          m_w       [2] = '{32, 16};
   logic [31:0] m_poly    [2] = '{32'h04C11DB7, 32'h00001021};
   logic [31:0] m_init    [2] = '{32'hFFFFFFFF, 32'h0000FFFF};
   logic [31:0] m_xor     [2] = '{32'hFFFFFFFF, 32'h00000000};
   logic        m_rin_rst [2] = '{1'b1, 1'b0};
   logic        m_rout_rst[2] = '{1'b1, 1'b0};
   logic [31:0] m_crc [2];
   logic        m_rin [2];
   logic        m_rout[2];

   logic [33:0] exp0_q[$];
   logic [33:0] exp1_q[$];

   int n_compared = 0;
   int n_mismatched = 0;
   int exp_acks0 = 0, exp_errs0 = 0, exp_acks1 = 0, exp_errs1 = 0;
   int seen_acks0 = 0, seen_errs0 = 0, seen_acks1 = 0, seen_errs1 = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wb0.ack) seen_acks0 <= seen_acks0 + 1;
         if (wb0.err) seen_errs0 <= seen_errs0 + 1;
         if (wb1.ack) seen_acks1 <= seen_acks1 + 1;
         if (wb1.err) seen_errs1 <= seen_errs1 + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wmask(input int w);
      return (w >= 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // Bit-serial update: one message bit folded into the register MSB per step.
   function automatic logic [31:0] model_byte(input int d, input logic [7:0] b);
      logic [7:0]  bb;
      logic [31:0] c;
      logic        top;
      bb = b;
      if (m_rin[d]) begin
         for (int i = 0; i < 8; i++) bb[3'(i)] = b[3'(7 - i)];
      end
      c = m_crc[d];
      for (int i = 7; i >= 0; i--) begin
         top = c[5'(m_w[d] - 1)] ^ bb[3'(i)];
         c = (c << 1) & wmask(m_w[d]);
         if (top) c = c ^ (m_poly[d] & wmask(m_w[d]));
      end
      return c;
   endfunction

   function automatic logic [31:0] model_result(input int d);
      logic [31:0] r;
      r = m_crc[d];
      if (m_rout[d]) begin
         r = '0;
         for (int i = 0; i < 32; i++) begin
            if (i < m_w[d]) r[5'(i)] = m_crc[d][5'(m_w[d] - 1 - i)];
         end
      end
      return (r ^ m_xor[d]) & wmask(m_w[d]);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_crc[d]  = m_init[d];
         m_rin[d]  = m_rin_rst[d];
         m_rout[d] = m_rout_rst[d];
      end
   endtask

   // Returns the expected {ack, err, dat_s} and advances the model state.
   function automatic logic [33:0] model_access(input int d, input logic wr, input logic [1:0] r,
                                                input logic [31:0] data, input logic [3:0] be);
      logic [33:0] e;
      e = {2'b10, 32'h0};
      case (r)
         2'd0: begin
            if (wr) begin
               m_rin[d]  = data[0];
               m_rout[d] = data[1];
               if (data[2]) m_crc[d] = m_init[d];
            end else begin
               e = {2'b10, 30'h0, m_rout[d], m_rin[d]};
            end
         end
         2'd1: begin
            if (wr) begin
               for (int l = 0; l < 4; l++) begin
                  if (be[2'(l)]) m_crc[d] = model_byte(d, data[5'(8 * l) +: 8]);
               end
            end else begin
               e = {2'b01, 32'h0};
            end
         end
         2'd2: e = wr ? {2'b01, 32'h0} : {2'b10, model_result(d)};
         default: e = wr ? {2'b01, 32'h0} : {2'b10, 32'h0};
      endcase
      return e;
   endfunction

   // One bus request: expectations pushed on drive, popped on the response cycle.
   // Entered and left at a falling edge.
   task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] r,
                                input logic [31:0] data, input logic [3:0] be,
                                output int stall_cycles, output logic [31:0] obs0,
                                output logic [31:0] obs1);
      logic [33:0] e0, e1, o0, o1;
      e0 = model_access(0, wr, r, data, be);
      e1 = model_access(1, wr, r, data, be);
      exp0_q.push_back(e0);
      exp1_q.push_back(e1);
      if (e0[33]) exp_acks0++; else exp_errs0++;
      if (e1[33]) exp_acks1++; else exp_errs1++;

      m_adr = ($urandom() & 32'hFFFF_FFF3) | {28'h0, r, 2'b00};
      m_dat = data;
      m_sel = be;
      m_we  = wr;
      m_cyc = 1'b1;
      m_stb = 1'b1;
      stall_cycles = 0;
      obs0 = '0;
      obs1 = '0;
      while (wb0.stall && stall_cycles < 50) begin
         @(negedge clk);
         stall_cycles++;
      end
      if (wb0.stall) begin
         checkOutput({tag, "/stall_timeout"}, 34'(stall_cycles), 34'd0);
         m_cyc = 1'b0;
         m_stb = 1'b0;
         void'(exp0_q.pop_front());
         void'(exp1_q.pop_front());
      end else begin
         @(posedge clk);
         #1;
         m_cyc = 1'b0;
         m_stb = 1'b0;
         m_we  = 1'b0;
         @(negedge clk);
         o0 = {wb0.ack, wb0.err, wb0.dat_s};
         o1 = {wb1.ack, wb1.err, wb1.dat_s};
         obs0 = wb0.dat_s;
         obs1 = wb1.dat_s;
         e0 = exp0_q.pop_front();
         e1 = exp1_q.pop_front();
         if (wr || !e0[33]) begin o0[31:0] = '0; e0[31:0] = '0; end
         if (wr || !e1[33]) begin o1[31:0] = '0; e1[31:0] = '0; end
         checkOutput({tag, "/crc32"}, o0, e0);
         checkOutput({tag, "/crc16"}, o1, e1);
      end
   endtask

   initial begin
      int          sc;
      logic [31:0] d0, d1;

      m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checkOutput("reset_resp32", {wb0.ack, wb0.err, wb0.dat_s}, 34'h0);
      checkOutput("reset_resp16", {wb1.ack, wb1.err, wb1.dat_s}, 34'h0);
      checkOutput("reset_stall", {32'h0, wb0.stall, wb1.stall}, 34'h0);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus("ctrl_reset", 1'b0, 2'd0, 32'h0, 4'hF, sc, d0, d1);
      applyStimulus("result_init", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);

      applyStimulus("wr_1234", 1'b1, 2'd1, 32'h34333231, 4'hF, sc, d0, d1);
      applyStimulus("wr_5678", 1'b1, 2'd1, 32'h38373635, 4'hF, sc, d0, d1);
      checkOutput("wr_5678_stall", 34'(sc), 34'd4);
      applyStimulus("wr_9", 1'b1, 2'd1, 32'hAABBCC39, 4'h1, sc, d0, d1);
      applyStimulus("check_rd", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);
      checkOutput("check_rd_stall", 34'(sc), 34'd1);
      checkOutput("check_crc32", 34'(d0), 34'hCBF43926);
      checkOutput("check_crc16", 34'(d1), 34'h000029B1);
      applyStimulus("status_idle", 1'b0, 2'd3, 32'h0, 4'hF, sc, d0, d1);

      applyStimulus("sel_none", 1'b1, 2'd1, 32'hFFFFFFFF, 4'h0, sc, d0, d1);
      applyStimulus("sel_none_rd", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);
      checkOutput("sel_none_stall", 34'(sc), 34'd0);

      applyStimulus("full_wr", 1'b1, 2'd1, 32'h5A3C_96E1, 4'hF, sc, d0, d1);
      applyStimulus("full_rd", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);
      checkOutput("full_rd_stall", 34'(sc), 34'd4);

      applyStimulus("clear", 1'b1, 2'd0, 32'h0000_0007, 4'hF, sc, d0, d1);
      applyStimulus("clear_rd", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);
      checkOutput("clear_crc32", 34'(d0), 34'h0);
      applyStimulus("ctrl_rd", 1'b0, 2'd0, 32'h0, 4'hF, sc, d0, d1);
      checkOutput("ctrl_rd_crc32", 34'(d0), 34'h3);

      applyStimulus("pre_err", 1'b1, 2'd1, 32'h11223344, 4'hF, sc, d0, d1);
      applyStimulus("wr_result", 1'b1, 2'd2, 32'hDEADBEEF, 4'hF, sc, d0, d1);
      applyStimulus("wr_status", 1'b1, 2'd3, 32'hFFFFFFFF, 4'hF, sc, d0, d1);
      applyStimulus("rd_data", 1'b0, 2'd1, 32'h0, 4'hF, sc, d0, d1);
      applyStimulus("post_err_rd", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);

      // Request abandoned while stalled must never be answered.
      applyStimulus("drop_wr", 1'b1, 2'd1, 32'h0BADF00D, 4'hF, sc, d0, d1);
      m_adr = 32'h8; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_cyc = 1'b0; m_stb = 1'b0;
      checkOutput("drop_no_resp", {30'h0, wb0.ack, wb0.err, wb1.ack, wb1.err}, 34'h0);
      repeat (4) @(negedge clk);
      checkOutput("drop_no_resp_later", {30'h0, wb0.ack, wb0.err, wb1.ack, wb1.err}, 34'h0);
      applyStimulus("drop_status", 1'b0, 2'd3, 32'h0, 4'hF, sc, d0, d1);
      applyStimulus("drop_result", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);

      applyStimulus("rst_wr", 1'b1, 2'd1, 32'hCAFEBABE, 4'hF, sc, d0, d1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid", {28'h0, wb0.stall, wb1.stall, wb0.ack, wb1.ack, wb0.err, wb1.err}, 34'h0);
      model_reset();
      repeat (2) @(negedge clk);
      checkOutput("rst_mid_hold", {28'h0, wb0.stall, wb1.stall, wb0.ack, wb1.ack, wb0.err, wb1.err}, 34'h0);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus("rst_status", 1'b0, 2'd3, 32'h0, 4'hF, sc, d0, d1);
      applyStimulus("rst_result", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);
      checkOutput("rst_result_crc32", 34'(d0), 34'h0);

      for (int k = 0; k < 8; k++) begin
         applyStimulus("rand_wr", 1'b1, 2'd1, $urandom(), 4'($urandom_range(0, 15)), sc, d0, d1);
         if (k == 4) applyStimulus("rand_ctrl", 1'b1, 2'd0, 32'h0000_0001, 4'hF, sc, d0, d1);
         applyStimulus("rand_rd", 1'b0, 2'd2, 32'h0, 4'hF, sc, d0, d1);
      end

      repeat (2) @(negedge clk);
      checkOutput("ack_count32", 34'(seen_acks0), 34'(exp_acks0));
      checkOutput("err_count32", 34'(seen_errs0), 34'(exp_errs0));
      checkOutput("ack_count16", 34'(seen_acks1), 34'(exp_acks1));
      checkOutput("err_count16", 34'(seen_errs1), 34'(exp_errs1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
